// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - handshake bundle for the immediate extension pipe
//
// Purpose: groups the input-side and output-side valid/ready streams of
//          imm_extend_pipe so they can be passed as one port.
// Signals:
//   in_valid/in_ready   input-side handshake
//   in_imm              immediate field (IN_WIDTH)
//   in_mode             extension mode (0 zero, 1 sign, 2 upper, 3 sign+shift)
//   in_tag              sideband tag (TAG_WIDTH)
//   out_valid/out_ready output-side handshake
//   out_data            extended operand (OUT_WIDTH)
//   out_tag             tag belonging to out_data
// Modports: master = producer/consumer side, slave = the extension pipe.
interface imm_extend_pipe_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int TAG_WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_imm;
    logic [1:0]           in_mode;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [TAG_WIDTH-1:0] out_tag;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate extender with two-entry skid buffer
//
// Purpose: extends an IN_WIDTH immediate to OUT_WIDTH using one of four modes
//          (zero, sign, upper, sign then shift left by SHIFT) and registers the
//          result behind a valid/ready handshake with full throughput.
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   bus        imm_extend_pipe_if.slave handshake bundle
//   stat_count (IMM_EXTEND_STATS_EN only) output transfer counter, wrapping
//   stat_stall (IMM_EXTEND_STATS_EN only) stalled-input cycle counter, saturating
// Optional feature macro: IMM_EXTEND_STATS_EN
module imm_extend_pipe #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 1,
    parameter int TAG_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    imm_extend_pipe_if.slave      bus
`ifdef IMM_EXTEND_STATS_EN
    ,
    output logic [15:0]           stat_count,
    output logic [15:0]           stat_stall
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t               state_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [OUT_WIDTH-1:0] main_data_q;
    logic [TAG_WIDTH-1:0] main_tag_q;
    logic [OUT_WIDTH-1:0] skid_data_q;
    logic [TAG_WIDTH-1:0] skid_tag_q;

    logic [OUT_WIDTH-1:0] ext_d;
    logic [OUT_WIDTH-1:0] zext;
    logic [OUT_WIDTH-1:0] sext;
    logic                 in_ready;
    logic                 in_fire;
    logic                 out_fire;

    // Width casts keep every mode legal when IN_WIDTH == OUT_WIDTH
    // (no zero-width replications).
    assign zext = OUT_WIDTH'(bus.in_imm);
    assign sext = OUT_WIDTH'($signed(bus.in_imm));

    always_comb begin
        ext_d = zext;
        case (bus.in_mode)
            2'd0:    ext_d = zext;
            2'd1:    ext_d = sext;
            2'd2:    ext_d = zext << (OUT_WIDTH - IN_WIDTH);
            default: ext_d = sext << SHIFT;
        endcase
    end

    // in_ready comes from registered state only; gating with reset keeps it low
    // for the whole time reset is asserted, including before the first edge.
    assign in_ready  = in_ready_q && !reset;
    assign in_fire   = bus.in_valid && in_ready;
    assign out_fire  = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_data_q;
    assign bus.out_tag   = main_tag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_data_q <= ext_d;
                        main_tag_q  <= bus.in_tag;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_q <= ext_d;
                        main_tag_q  <= bus.in_tag;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end else if (in_fire) begin
                        // Main is held for the stalled consumer; park new data.
                        skid_data_q <= ext_d;
                        skid_tag_q  <= bus.in_tag;
                        in_ready_q  <= 1'b0;
                        state_q     <= ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_data_q <= skid_data_q;
                        main_tag_q  <= skid_tag_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMM_EXTEND_STATS_EN
    logic [15:0] stat_count_q;
    logic [15:0] stat_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_count_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (out_fire) begin
                stat_count_q <= stat_count_q + 16'd1;
            end
            if (bus.in_valid && !in_ready && stat_stall_q != 16'hFFFF) begin
                stat_stall_q <= stat_stall_q + 16'd1;
            end
        end
    end

    assign stat_count = stat_count_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, registered successor to the plain zero-extension block.
- Takes an immediate field of IN_WIDTH bits and produces an OUT_WIDTH-bit operand.
- Four selectable extension modes; valid/ready handshake on both sides.
- Two-entry skid buffer gives full throughput under back-pressure; sits between decode and the ALU operand mux.

Parameters:
IN_WIDTH, 8, width of immediate field; 1 <= IN_WIDTH <= OUT_WIDTH
OUT_WIDTH, 16, width of extended operand
SHIFT, 1, left-shift amount for mode 3 (branch offset); 0 <= SHIFT < OUT_WIDTH
TAG_WIDTH, 4, width of sideband tag carried alongside data

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input transaction present
in_ready  output  1  block can accept input this cycle
in_imm  input  IN_WIDTH  immediate field
in_mode  input  2  extension mode: 0 zero, 1 sign, 2 upper, 3 sign+shift
in_tag  input  TAG_WIDTH  sideband tag, passed through unchanged
out_valid  output  1  extended result present
out_ready  input  1  consumer accepts result this cycle
out_data  output  OUT_WIDTH  extended immediate
out_tag  output  TAG_WIDTH  tag of the result on out_data

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Extension is combinational on the input side; the result is registered.
  - Mode 0: upper OUT_WIDTH-IN_WIDTH bits = 0, low bits = in_imm.
  - Mode 1: upper bits = in_imm[IN_WIDTH-1].
  - Mode 2: in_imm placed in the top IN_WIDTH bits; low OUT_WIDTH-IN_WIDTH bits = 0.
  - Mode 3: sign-extend to OUT_WIDTH, then shift left by SHIFT; bits shifted out are discarded, low SHIFT bits = 0.
- IN_WIDTH == OUT_WIDTH: modes 0, 1 and 2 all give out_data = in_imm; mode 3 gives in_imm << SHIFT.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Latency: an accepted input appears on out_data/out_valid on the next cycle when the output stage is empty or draining. Throughput is 1 per cycle.
- Storage is a main register (drives outputs) plus a skid register. States:
  - EMPTY: in_ready=1, out_valid=0. Input transfer -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Input and output transfer together: main reloads with new data, stay ONE.
    - Output transfer only -> EMPTY.
    - Input transfer only -> TWO (new data goes to skid).
    - Neither: hold.
  - TWO: in_ready=0, out_valid=1.
    - Output transfer: skid moves to main -> ONE.
    - Otherwise hold.
- Ordering is strictly FIFO. Data and tag in a held entry never change while out_valid && !out_ready.
- in_ready depends only on state, never combinationally on out_ready.
- in_imm, in_mode and in_tag are don't-care when in_valid=0. in_valid=1 with in_ready=0 is ignored, with no state change.
- Reset: state -> EMPTY on the first edge with reset=1.
  - out_valid=0, out_data=0, out_tag=0, in_ready=0 while reset is high, in_ready=1 on the first cycle after reset is released.
  - Reset mid-operation discards main and skid contents with no output transfer.
  - Reset has priority over any simultaneous transfer.

Optional Feature:
- Macro: IMM_EXTEND_STATS_EN.
- When defined, adds:
  - Output stat_count, 16 bits: increments by 1 on each output transfer, wraps 0xFFFF -> 0x0000, cleared to 0 by reset.
  - Output stat_stall, 16 bits: increments by 1 each cycle with in_valid && !in_ready, saturates at 0xFFFF, cleared to 0 by reset.
- When not defined, neither port nor counter logic exists. Handshake and datapath behaviour are identical in both builds.

Test Plan:
- Modes (IN_WIDTH=8, OUT_WIDTH=16, SHIFT=1), in_imm=0x80, out_ready=1:
  - Mode 0 -> 0x0080; mode 1 -> 0xFF80; mode 2 -> 0x8000; mode 3 -> 0xFF00.
  - Each appears one cycle after acceptance with matching tag.
- Positive operand, in_imm=0x35:
  - Mode 1 -> 0x0035; mode 3 -> 0x006A; mode 2 -> 0x3500.
- Back-pressure: out_ready=0, three consecutive inputs with tags 1,2,3:
  - Tags 1 and 2 accepted; in_ready=0 on the cycle after the second acceptance; tag 3 held off.
  - Raise out_ready -> outputs in order 1,2,3; no loss or duplication; out_data stable while stalled.
- Streaming: 32 back-to-back inputs with out_ready=1 -> 32 outputs in 32 consecutive cycles; in_ready stays 1.
- Reset mid-operation in state TWO:
  - Next cycle: out_valid=0, out_data=0, out_tag=0, in_ready=0.
  - After release, in_ready=1 and the first new input is the first output.
- With IMM_EXTEND_STATS_EN:
  - 5 output transfers -> stat_count=5.
  - 3 stalled input cycles -> stat_stall=3.
  - Preload stat_count to 0xFFFF via transfers -> wraps to 0x0000.
